ex_mem_stage_buffer: RTL and testbench

//  Consumer end of the execute interface: accepts iExecute results (alu_result, branch_target, zero) plus

---
 rtl/ex_mem_stage_buffer.sv | 168 ++++++++++++++++
 tb/tb_ex_mem_stage_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_buffer.sv
// ex_mem_stage_buffer
//   EX/MEM boundary of the pipelined LEGv8 core. Accepts execute results over a
//   valid/ready handshake and resolves the branch decision when an entry is
//   accepted. It presents one registered entry to the memory stage.
//   A two-entry skid buffer (main + skid) keeps in_ready registered. As a result,
//   a stall on out_ready never reaches the execute stage combinationally.
//
// Optional feature: define EX_MEM_STALL_CNT_EN to add two saturating 32-bit
//   counters, stall_cycles and taken_count. Only reset clears them.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid / in_ready          execute-side handshake (in_ready registered)
//   alu_result, branch_target,
//   zero, store_data, write_reg,
//   ctrl_in                      execute payload; ctrl_in = {uncond_branch,
//                                branch, mem_read, mem_write, mem_to_reg,
//                                reg_write}
//   flush                        drop every buffered entry
//   out_valid / out_ready        memory-side handshake
//   mem_alu_result, mem_store_data,
//   mem_write_reg, mem_ctrl      buffered payload; mem_ctrl = {mem_read,
//                                mem_write, mem_to_reg, reg_write}
//   pc_src, pc_branch_target     branch-taken indication and target
//   stall_cycles, taken_count    (EX_MEM_STALL_CNT_EN only)
module ex_mem_stage_buffer #(
  parameter int WORD_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              zero,
  input  logic [WORD_W-1:0] store_data,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [5:0]        ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] mem_alu_result,
  output logic [WORD_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_write_reg,
  output logic [3:0]        mem_ctrl,
  output logic              pc_src,
  output logic [WORD_W-1:0] pc_branch_target
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       taken_count
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] target;
    logic [WORD_W-1:0] store;
    logic [REG_W-1:0]  wreg;
    logic [3:0]        ctrl;
    logic              taken;
  } entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t state_p1, state_nxt;
  entry_t main_p1, skid_p1;
  entry_t in_entry_p0;
  logic   in_fire, out_fire;
  logic   load_main_in, load_main_skid, load_skid_in;

  // Stage 0: capture the execute result. The branch decision is resolved here.
  // Only the taken bit is kept, so the zero flag is not stored.
  always_comb begin
    in_entry_p0.alu    = alu_result;
    in_entry_p0.target = branch_target;
    in_entry_p0.store  = store_data;
    in_entry_p0.wreg   = write_reg;
    in_entry_p0.ctrl   = ctrl_in[3:0];
    in_entry_p0.taken  = ctrl_in[5] | (ctrl_in[4] & zero);
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt      = state_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (in_fire) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt    = TWO;
          load_skid_in = 1'b1;
        end else if (out_fire) begin
          state_nxt    = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low in this state, so only the drain path is possible.
        if (out_fire) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage 1: main/skid registers and the memory-stage view of the main entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_p1 <= EMPTY;
      in_ready <= 1'b0;
      main_p1  <= '0;
      skid_p1  <= '0;
    end else if (flush) begin
      // Payload is left as is. pc_src and out_valid are masked by state.
      state_p1 <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_p1 <= state_nxt;
      in_ready <= (state_nxt != TWO);
      if (load_main_in)   main_p1 <= in_entry_p0;
      if (load_main_skid) main_p1 <= skid_p1;
      if (load_skid_in)   skid_p1 <= in_entry_p0;
    end
  end

  assign out_valid        = (state_p1 != EMPTY);
  assign mem_alu_result   = main_p1.alu;
  assign mem_store_data   = main_p1.store;
  assign mem_write_reg    = main_p1.wreg;
  assign mem_ctrl         = main_p1.ctrl;
  assign pc_branch_target = main_p1.target;
  assign pc_src           = out_valid & main_p1.taken;

`ifdef EX_MEM_STALL_CNT_EN
  // Flush does not clear the counters. A transfer out that a flush
  // cancels is not counted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      taken_count  <= '0;
    end else begin
      if (out_valid && !out_ready)
        stall_cycles <= sat_inc(stall_cycles);
      if (out_fire && !flush && main_p1.taken)
        taken_count <= sat_inc(taken_count);
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
module tb_ex_mem_stage_buffer;
  localparam int WORD_W = 64;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] alu_result;
  logic [WORD_W-1:0] branch_target;
  logic              zero;
  logic [WORD_W-1:0] store_data;
  logic [REG_W-1:0]  write_reg;
  logic [5:0]        ctrl_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] mem_alu_result;
  logic [WORD_W-1:0] mem_store_data;
  logic [REG_W-1:0]  mem_write_reg;
  logic [3:0]        mem_ctrl;
  logic              pc_src;
  logic [WORD_W-1:0] pc_branch_target;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       taken_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage_buffer #(.WORD_W(WORD_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .branch_target(branch_target), .zero(zero),
    .store_data(store_data), .write_reg(write_reg), .ctrl_in(ctrl_in),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_write_reg(mem_write_reg), .mem_ctrl(mem_ctrl),
    .pc_src(pc_src), .pc_branch_target(pc_branch_target)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cycles(stall_cycles), .taken_count(taken_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock. Inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] alu, input logic [63:0] tgt, input logic z,
                       input logic [63:0] sd, input logic [4:0] wr, input logic [5:0] c);
    in_valid      = 1'b1;
    alu_result    = alu;
    branch_target = tgt;
    zero          = z;
    store_data    = sd;
    write_reg     = wr;
    ctrl_in       = c;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; alu_result = '0; branch_target = '0;
    zero = 1'b0; store_data = '0; write_reg = '0; ctrl_in = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset held for two cycles.
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_pc_src", pc_src, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_alu", mem_alu_result, 0);
    check("rst_ctrl", mem_ctrl, 0);
    reset_n = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // LDUR: mem_read|mem_to_reg|reg_write
    out_ready = 1'b1;
    drive(64'd80, 64'd0, 1'b0, 64'h55, 5'd3, 6'b001011);
    step();
    in_valid = 1'b0;
    check("ldur_valid", out_valid, 1);
    check("ldur_alu", mem_alu_result, 80);
    check("ldur_ctrl", mem_ctrl, 4'b1011);
    check("ldur_wreg", mem_write_reg, 3);
    check("ldur_sd", mem_store_data, 64'h55);
    check("ldur_pc_src", pc_src, 0);
    step();
    check("ldur_drained", out_valid, 0);

    // CBZ taken, then the same CBZ not taken. The second entry is accepted
    // in the cycle the first one leaves.
    drive(64'd0, 64'd16, 1'b1, 64'd0, 5'd0, 6'b010000);
    step();
    check("cbz_t_pc_src", pc_src, 1);
    check("cbz_t_target", pc_branch_target, 16);
    drive(64'd0, 64'd16, 1'b0, 64'd0, 5'd0, 6'b010000);
    step();
    in_valid = 1'b0;
    check("cbz_nt_valid", out_valid, 1);
    check("cbz_nt_pc_src", pc_src, 0);
    // Unconditional B taken regardless of zero
    drive(64'd0, 64'd64, 1'b0, 64'd0, 5'd0, 6'b100000);
    step();
    in_valid = 1'b0;
    check("b_pc_src", pc_src, 1);
    check("b_target", pc_branch_target, 64);
    step();
    check("b_drained", out_valid, 0);
    check("b_drained_pc_src", pc_src, 0);

    // Backpressure: ADD 30, SUB 0, third (55) held off.
    out_ready = 1'b0;
    drive(64'd30, 64'd0, 1'b0, 64'd0, 5'd1, 6'b000001);
    step();
    check("bp_rdy1", in_ready, 1);
    check("bp_alu1", mem_alu_result, 30);
    drive(64'd0, 64'd0, 1'b1, 64'd0, 5'd2, 6'b000001);
    step();
    check("bp_rdy2", in_ready, 0);
    check("bp_hold_alu", mem_alu_result, 30);
    drive(64'd55, 64'd0, 1'b0, 64'd0, 5'd4, 6'b000001);
    step();
    check("bp_rdy3", in_ready, 0);
    check("bp_stable_alu", mem_alu_result, 30);
    check("bp_stable_wreg", mem_write_reg, 1);
    out_ready = 1'b1;
    step();
    check("bp_second_alu", mem_alu_result, 0);
    check("bp_second_wreg", mem_write_reg, 2);
    check("bp_rdy4", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_third_alu", mem_alu_result, 55);
    check("bp_third_valid", out_valid, 1);
    step();
    check("bp_drained", out_valid, 0);

    // Flush while TWO, with in and out both active.
    out_ready = 1'b0;
    drive(64'd100, 64'd0, 1'b0, 64'd0, 5'd5, 6'b000001);
    step();
    drive(64'd101, 64'd0, 1'b0, 64'd0, 5'd6, 6'b000001);
    step();
    check("fl_pre_rdy", in_ready, 0);
    drive(64'd102, 64'd0, 1'b0, 64'd0, 5'd7, 6'b000001);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_pc_src", pc_src, 0);
    step();
    check("fl_still_empty", out_valid, 0);

    // Reset in the middle of operation clears the payload.
    out_ready = 1'b0;
    drive(64'd77, 64'd8, 1'b0, 64'd9, 5'd9, 6'b100011);
    step();
    in_valid = 1'b0;
    check("mr_pre_valid", out_valid, 1);
    reset_n = 1'b0;
    step();
    check("mr_out_valid", out_valid, 0);
    check("mr_alu", mem_alu_result, 0);
    check("mr_target", pc_branch_target, 0);
    check("mr_in_ready", in_ready, 0);
    reset_n = 1'b1;
    step();
    check("mr_rel_rdy", in_ready, 1);

`ifdef EX_MEM_STALL_CNT_EN
    check("cnt_rst_stall", stall_cycles, 0);
    check("cnt_rst_taken", taken_count, 0);
    out_ready = 1'b0;
    drive(64'd0, 64'd64, 1'b0, 64'd0, 5'd0, 6'b100000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("cnt_stall", stall_cycles, 5);
    out_ready = 1'b1;
    step();
    check("cnt_taken", taken_count, 1);
    check("cnt_stall_after", stall_cycles, 5);
    check("cnt_empty", out_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
